ripple_8: RTL and testbench

8-bit ripple-carry adder with registered outputs, for datapath blocks that need a small, predictable-area adder with a valid qualifier. The carry path is an explicit chain of eight 1-bit full-adder cells; no vendor adder or `+` inference on the sum path. Result, carry-out and signed-overflow flag are registered and qualified by `out_valid`.

---
 rtl/ripple_8.sv | 115 +++++++++++
 tb/tb_ripple_8.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ripple_8.sv
// ripple_8: 8-bit ripple-carry adder with registered sum, carry-out and
//   signed-overflow flag, qualified by out_valid.
// Latency: 1 cycle by default; 2 cycles when RIPPLE_8_INREG_EN is defined
//   (adds an input register stage in front of the ripple chain).
// Backpressure: none; every in_valid cycle is accepted, one result per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands and cin valid this cycle
//   in1, in2   8-bit operands (unsigned or two's complement)
//   cin        carry-in to bit 0
//   sum        registered (in1 + in2 + cin) mod 256
//   cout       registered carry out of bit 7
//   ovf        registered signed overflow (carry into bit 7 ^ carry out)
//   out_valid  sum/cout/ovf carry a new result this cycle
module ripple_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic       out_valid
);

  // Operands as seen by the ripple chain.
  logic [7:0] stg_a;
  logic [7:0] stg_b;
  logic       stg_c;
  logic       stg_vld;

`ifdef RIPPLE_8_INREG_EN
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       c_q;
  logic       vld_q;

  // Operand registers load every cycle; vld_q marks whether the captured
  // operands are meaningful, so no enable is needed on the data path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      c_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= in1;
      b_q   <= in2;
      c_q   <= cin;
      vld_q <= in_valid;
    end
  end

  assign stg_a   = a_q;
  assign stg_b   = b_q;
  assign stg_c   = c_q;
  assign stg_vld = vld_q;
`else
  assign stg_a   = in1;
  assign stg_b   = in2;
  assign stg_c   = cin;
  assign stg_vld = in_valid;
`endif

  // Explicit chain of eight full-adder cells; carry[i] is the carry into bit i.
  logic [8:0] carry;
  logic [7:0] sum_d;

  assign carry[0] = stg_c;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    logic p;
    assign p          = stg_a[i] ^ stg_b[i];
    assign sum_d[i]   = p ^ carry[i];
    assign carry[i+1] = (stg_a[i] & stg_b[i]) | (carry[i] & p);
  end

  logic       cout_d;
  logic       ovf_d;
  assign cout_d = carry[8];
  assign ovf_d  = carry[7] ^ carry[8];

  logic [7:0] sum_q;
  logic       cout_q;
  logic       ovf_q;
  logic       out_valid_q;

  // Result registers hold their last value on idle cycles so downstream logic
  // may sample them at any time after a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= 8'h00;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= stg_vld;
      if (stg_vld) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_8.sv
// tb_ripple_8: scoreboard bench for ripple_8. Stimulus pushes expected
//   results (from integer arithmetic) into a queue; a monitor pops and
//   compares on every out_valid, and checks hold/reset values otherwise.
module tb_ripple_8;

`ifdef RIPPLE_8_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       out_valid;

  ripple_8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s;
    int c;
    int o;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/carry and signed
  // range test for overflow.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
    exp_t e;
    int   u;
    int   sv;
    u   = int'(a) + int'(b) + int'(c);
    sv  = int'($signed(a)) + int'($signed(b)) + int'(c);
    e.s = u % 256;
    e.c = (u > 255) ? 1 : 0;
    e.o = (sv > 127 || sv < -128) ? 1 : 0;
    e.due = 0;
    return e;
  endfunction

  // Called at posedge+1; the operands are sampled on the next edge.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    exp_t e;
    in_valid = v;
    in1      = a;
    in2      = b;
    cin      = c;
    if (v) begin
      e     = model(a, b, c);
      e.due = cyc + LAT;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, $urandom);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_vld", out_valid, 0);
      held.s = 0; held.c = 0; held.o = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("sum", sum, e.s);
        chk("cout", cout, e.c);
        chk("ovf", ovf, e.o);
        held = e;
      end
    end else begin
      chk("hold_sum", sum, held.s);
      chk("hold_cout", cout, held.c);
      chk("hold_ovf", ovf, held.o);
      if (q.size() != 0 && q[0].due <= cyc) begin
        chk("missing_out_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    held.s = 0; held.c = 0; held.o = 0; held.due = 0;
    rst = 1'b1;
    in_valid = 1'b0; in1 = 8'h00; in2 = 8'h00; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors
    drive(1'b1, 8'h05, 8'h03, 1'b0);
    idle(3);
    drive(1'b1, 8'h7F, 8'h01, 1'b1);
    idle(2);
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    idle(2);

    // Back-to-back, then hold (last result FF / 0 / 1)
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    drive(1'b1, 8'h7F, 8'h7F, 1'b1);
    idle(5);

    // Reset with an accepted operand set in flight: not expected to emerge.
    in_valid = 1'b1; in1 = 8'h7F; in2 = 8'h01; cin = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst_imm_sum", sum, 0);
    chk("rst_imm_cout", cout, 0);
    chk("rst_imm_ovf", ovf, 0);
    chk("rst_imm_vld", out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    drive(1'b1, 8'h05, 8'h03, 1'b0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom);
    end
    idle(2);

    // Drain: everything pushed must have been observed.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
